// File: rtl/pending_encoder_pkg.sv
// pending_encoder_pkg: shared widths and FSM state type for the pending encoder
package pending_encoder_pkg;
  localparam int IDX_W = 5;
  localparam int NUM_LINES = 32;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/pending_encoder_priority_encoder_32.sv
// priority_encoder_32: first set bit of vec searching upward from start, wrapping 31->0
module priority_encoder_32
  import pending_encoder_pkg::*;
(
  input  logic [NUM_LINES-1:0] vec,
  input  logic [IDX_W-1:0]     start,
  output logic [IDX_W-1:0]     idx,
  output logic                 found
);
  logic [NUM_LINES-1:0] rot;
  logic [IDX_W-1:0] pos;
  // rotate so bit 'start' lands at 0, then pick the lowest set bit of the rotated vector
  always_comb begin
    rot = '0;
    pos = '0;
    for (int i = 0; i < NUM_LINES; i++) rot[i] = vec[IDX_W'(i) + start];
    for (int i = NUM_LINES - 1; i >= 0; i--) if (rot[i]) pos = IDX_W'(i);
  end
  assign idx = pos + start;
  assign found = |vec;
endmodule

// File: rtl/pending_encoder.sv
// pending_encoder: sticky pending bits served one at a time through a valid/ready grant
module pending_encoder
  import pending_encoder_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] req,
  input  logic [NUM_LINES-1:0] mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic [NUM_LINES-1:0] pending,
  output logic                 any_pending
);
  state_t state, state_next;
  logic [IDX_W-1:0] last_idx, start, sel_idx;
  logic [NUM_LINES-1:0] eligible, clr;
  logic found, hs;
  assign eligible = pending & ~mask;
  assign any_pending = |eligible;
  assign hs = (state == HOLD) && out_valid && out_ready;
  assign clr = hs ? NUM_LINES'(1) << out_idx : '0;
  assign start = ROUND_ROBIN ? last_idx + IDX_W'(1) : '0;
  priority_encoder_32 u_sel (
    .vec(eligible),
    .start(start),
    .idx(sel_idx),
    .found(found)
  );
  // grant when something is eligible, hold until the consumer takes it
  always_comb begin
    state_next = state;
    state_next = (state == IDLE) ? (found ? HOLD : IDLE) : (hs ? IDLE : HOLD);
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  // pending latch (set wins over clear) and registered grant outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      out_valid <= 1'b0;
      out_idx <= '0;
      last_idx <= '1;
    end else begin
      pending <= (pending & ~clr) | req;
      if (state == IDLE && found) begin
        out_idx <= sel_idx;
        out_valid <= 1'b1;
      end
      if (hs) begin
        out_valid <= 1'b0;
        last_idx <= out_idx;
      end
    end
endmodule

// File: tb/tb_pending_encoder.sv
// tb_pending_encoder: directed scoreboard bench for fixed and rotating pending encoders
module tb_pending_encoder;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] req, mask;
  logic out_ready;
  logic out_valid, rr_valid;
  logic [4:0] out_idx, rr_idx;
  logic [31:0] pending, rr_pending;
  logic any_pending, rr_any;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pending_encoder #(.ROUND_ROBIN(1'b0)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .pending(pending), .any_pending(any_pending)
  );

  pending_encoder #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .out_valid(rr_valid), .out_ready(out_ready), .out_idx(rr_idx),
    .pending(rr_pending), .any_pending(rr_any)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pop one expected index per observed handshake; consecutive grants must be 2 cycles apart
  task automatic collect(input int n, input bit rr);
    int last_cyc;
    int waited;
    last_cyc = -1;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      while (!((rr ? rr_valid : out_valid) && out_ready) && waited < 100) begin
        tick();
        waited++;
      end
      if (waited >= 100) begin
        check("grant_timeout", 32'(waited), 32'd0);
        exp_q.delete();
        return;
      end
      check(rr ? "rr_grant_idx" : "grant_idx", 32'(rr ? rr_idx : out_idx), 32'(exp_q.pop_front()));
      if (last_cyc >= 0) check("grant_gap", 32'(cyc - last_cyc), 32'd2);
      last_cyc = cyc;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    mask = '0;
    out_ready = 1'b0;
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_any", 32'(any_pending), 32'd0);
    check("rst_rr_state", {rr_pending[30:0], rr_valid}, 32'd0);
    check("rst_rr_any", 32'(rr_any), 32'd0);
    rst = 1'b0;
    // ready with nothing pending does nothing
    out_ready = 1'b1;
    tick();
    check("idle_ready_valid", 32'(out_valid), 32'd0);
    check("idle_ready_pending", pending, 32'd0);
    // two lines at once: lowest first, then the other
    req = 32'h0000_0090;
    tick();
    req = '0;
    check("latch_pending", pending, 32'h0000_0090);
    check("latch_not_yet_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(4);
    exp_q.push_back(7);
    collect(2, 1'b0);
    check("drain_pending", pending, 32'd0);
    // mask gating and mask-independence of a held grant
    out_ready = 1'b0;
    mask = 32'hFFFF_FFFF;
    req = 32'h8000_0001;
    tick();
    req = '0;
    check("masked_pending", pending, 32'h8000_0001);
    check("masked_any", 32'(any_pending), 32'd0);
    tick();
    check("masked_no_grant", 32'(out_valid), 32'd0);
    mask = 32'h0000_0001;
    #1;
    check("partial_mask_any", 32'(any_pending), 32'd1);
    tick();
    check("mask_grant_valid", 32'(out_valid), 32'd1);
    check("mask_grant_idx", 32'(out_idx), 32'd31);
    mask = 32'hFFFF_FFFF;
    tick();
    check("hold_vs_mask_idx", 32'(out_idx), 32'd31);
    check("hold_vs_mask_valid", 32'(out_valid), 32'd1);
    mask = '0;
    out_ready = 1'b1;
    exp_q.push_back(31);
    exp_q.push_back(0);
    collect(2, 1'b0);
    // stall: grant held while another request arrives
    out_ready = 1'b0;
    req = 32'h0000_0008;
    tick();
    req = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      req = (k % 2 == 0) ? 32'h0000_0002 : 32'h0;
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_idx", 32'(out_idx), 32'd3);
    end
    req = '0;
    check("stall_pending", pending, 32'h0000_000A);
    out_ready = 1'b1;
    exp_q.push_back(3);
    exp_q.push_back(1);
    collect(2, 1'b0);
    // a new request on the served line in the handshake cycle keeps it pending
    out_ready = 1'b0;
    req = 32'h0000_0200;
    tick();
    req = '0;
    tick();
    check("setwin_grant", 32'(out_idx), 32'd9);
    out_ready = 1'b1;
    req = 32'h0000_0200;
    tick();
    req = '0;
    check("setwin_pending", pending, 32'h0000_0200);
    check("setwin_gap_valid", 32'(out_valid), 32'd0);
    tick();
    check("setwin_regrant_valid", 32'(out_valid), 32'd1);
    check("setwin_regrant_idx", 32'(out_idx), 32'd9);
    tick();
    check("setwin_final_pending", pending, 32'd0);
    // asynchronous reset in the middle of a held grant
    out_ready = 1'b0;
    req = 32'h0000_0020;
    tick();
    req = '0;
    tick();
    check("pre_rst_idx", 32'(out_idx), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_pending", pending, 32'd0);
    check("async_rst_idx", 32'(out_idx), 32'd0);
    req = 32'h0000_0040;
    tick();
    check("rst_drops_req", pending, 32'd0);
    rst = 1'b0;
    req = 32'h0000_0004;
    tick();
    req = '0;
    check("post_rst_latch", pending, 32'h0000_0004);
    tick();
    check("post_rst_grant", 32'(out_idx), 32'd2);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    // rotating priority with every line held pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    mask = '0;
    req = 32'hFFFF_FFFF;
    tick();
    for (int k = 0; k < 32; k++) exp_q.push_back(k);
    exp_q.push_back(0);
    collect(33, 1'b1);
    check("fixed_always_lowest", 32'(out_idx), 32'd0);
    // only eligible line equals the last granted one: still granted
    mask = 32'hFFFF_FFFE;
    tick();
    check("rr_single_valid", 32'(rr_valid), 32'd1);
    check("rr_single_idx", 32'(rr_idx), 32'd0);
    req = '0;
    mask = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pending_encoder.md
PENDING_ENCODER -- requirements
Module: pending_encoder

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 0: 0 selects fixed lowest-index priority, 1 selects rotating priority.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 32 bits: one-hot or multi-hot request pulses; bit i requests line i.
REQ-005 SHALL have port mask, input, 32 bits: bit i = 1 makes line i ineligible for selection; it does not block latching.
REQ-006 SHALL have port out_valid, output, 1 bit: out_idx holds a selected line.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts out_idx.
REQ-008 SHALL have port out_idx, output, 5 bits: binary index of the selected line; bit i of a 32-way decode.
REQ-009 SHALL have port pending, output, 32 bits: sticky pending register.
REQ-010 SHALL have port any_pending, output, 1 bit: OR of pending & ~mask.

Function
REQ-011 SHALL set pending[i] on every clk edge where req[i]=1; the bit stays set until it is served.
REQ-012 SHALL use a two-state FSM, IDLE and HOLD.
REQ-013 IDLE: if pending & ~mask is nonzero, SHALL register the selected index into out_idx, assert out_valid, and go to HOLD; otherwise SHALL stay in IDLE with out_valid=0.
REQ-014 HOLD: SHALL keep out_idx and out_valid=1 stable until out_valid & out_ready, independent of later mask or req changes.
REQ-015 On a HOLD handshake SHALL clear pending[out_idx], deassert out_valid, and return to IDLE on the next cycle; no back-to-back grants, so the minimum grant spacing is 2 cycles.
REQ-016 If req[out_idx]=1 in the same cycle as the handshake, SHALL leave pending[out_idx] set (set wins over clear).
REQ-017 Latency: req at edge N -> pending visible after N -> out_valid after edge N+1, provided the FSM is in IDLE.
REQ-018 ROUND_ROBIN=0 SHALL select the lowest index i with pending[i] & ~mask[i].
REQ-019 ROUND_ROBIN=1 SHALL search upward from last_idx+1, wrapping 31->0, and select the first eligible bit; last_idx updates only on a handshake.
REQ-020 With ROUND_ROBIN=1 and only one eligible bit, equal to last_idx, SHALL still select that bit (the wrap covers it).
REQ-021 any_pending SHALL be combinational from the current pending and mask.
REQ-022 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-023 On rst=1, SHALL asynchronously set pending=0, out_valid=0, out_idx=0, last_idx=31 (so the first rotating search starts at 0), and FSM=IDLE.
REQ-024 Reset during HOLD SHALL abort the grant without clearing beyond REQ-023, and SHALL drop any req sampled in that cycle.
REQ-025 After rst deasserts, the first latch SHALL occur on the next clk edge.

Structure
REQ-026 A shared package SHALL hold IDX_W=5, NUM_LINES=32, and the FSM state enum {IDLE, HOLD}.
REQ-027 The selection logic SHALL be one combinational sub-module, priority_encoder_32 (inputs: vector and start index; outputs: index and found flag), used for both priority modes.
REQ-028 pending, out_idx, out_valid, last_idx and the FSM state SHALL be the only registers.

Verification
REQ-029 Fixed mode: pulse req=0x0000_0090 with mask=0, out_ready=1 -> out_idx=4 then out_idx=7 on successive grants, 2 cycles apart; pending ends at 0.
REQ-030 Mask: pending=0x8000_0001 with mask=0x0000_0001 -> out_idx=31; then clear mask -> out_idx=0; any_pending=0 while mask=0xFFFF_FFFF.
REQ-031 Stall: grant idx 3 with out_ready=0 for 5 cycles while req[1] pulses -> out_idx stays 3 and out_valid stays 1; after the handshake the next grant is 1.
REQ-032 Set-wins: handshake on idx 9 with req[9]=1 in the same cycle -> pending[9] remains 1 and idx 9 is re-granted.
REQ-033 Rotating mode: all 32 bits held pending, out_ready=1 -> grants 0,1,...,31,0 in order, showing wrap-around.
REQ-034 Reset: assert rst asynchronously mid-HOLD -> out_valid=0, pending=0 immediately, without waiting for a clk edge.
